// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register for a five-stage MIPS pipeline.
//                Latches the decode control bundle (EX/M/WB), register read
//                data, sign-extended immediate, next PC and register
//                specifiers. Detects load-use hazards against the load in EX,
//                requests a one-cycle upstream stall and injects a bubble.
//                Honours branch flush and a global hold, and counts inserted
//                bubbles in a saturating debug counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n                      clock, asynchronous active-low reset
//    ctlex_in  [3:0]                 {RegDst, ALUOp[1:0], ALUSrc}
//    ctlm_in   [2:0]                 {Branch, MemRead, MemWrite}
//    ctlwb_in  [1:0]                 {RegWrite, MemtoReg}
//    id_valid                        decode slot holds a real instruction
//    npc_in, rdata1_in, rdata2_in,
//    sext_in   [DW-1:0]              next PC, rs data, rt data, immediate
//    rs_in, rt_in, rd_in [4:0]       register specifiers
//    flush                           kill the decode slot (taken branch)
//    hold                            freeze this register (downstream stall)
//    ex_out, m_out, wb_out           registered control bundle
//    npc_out, rdata1_out, rdata2_out,
//    sext_out  [DW-1:0]              registered datapath
//    rs_out, rt_out, rd_out [4:0]    registered specifiers
//    ex_valid                        EX slot holds a real instruction
//    stall_out                       combinational: hold PC and IF/ID
//    bubble_cnt [CW-1:0]             saturating count of inserted bubbles
// ============================================================================
module id_ex_stage #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic [3:0]    ctlex_in,
    input  logic [2:0]    ctlm_in,
    input  logic [1:0]    ctlwb_in,
    input  logic          id_valid,
    input  logic [DW-1:0] npc_in,
    input  logic [DW-1:0] rdata1_in,
    input  logic [DW-1:0] rdata2_in,
    input  logic [DW-1:0] sext_in,
    input  logic [4:0]    rs_in,
    input  logic [4:0]    rt_in,
    input  logic [4:0]    rd_in,
    input  logic          flush,
    input  logic          hold,

    output logic [3:0]    ex_out,
    output logic [2:0]    m_out,
    output logic [1:0]    wb_out,
    output logic [DW-1:0] npc_out,
    output logic [DW-1:0] rdata1_out,
    output logic [DW-1:0] rdata2_out,
    output logic [DW-1:0] sext_out,
    output logic [4:0]    rs_out,
    output logic [4:0]    rt_out,
    output logic [4:0]    rd_out,
    output logic          ex_valid,
    output logic          stall_out,
    output logic [CW-1:0] bubble_cnt
);

    localparam logic [CW-1:0] c_CNT_MAX = '1;
    localparam logic [CW-1:0] c_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Bit positions inside the control bundles
    localparam int c_ALUSRC_BIT   = 0;
    localparam int c_MEMWRITE_BIT = 0;
    localparam int c_MEMREAD_BIT  = 1;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    logic [3:0]    ex_q,       ex_d;
    logic [2:0]    m_q,        m_d;
    logic [1:0]    wb_q,       wb_d;
    logic [DW-1:0] npc_q,      npc_d;
    logic [DW-1:0] rdata1_q,   rdata1_d;
    logic [DW-1:0] rdata2_q,   rdata2_d;
    logic [DW-1:0] sext_q,     sext_d;
    logic [4:0]    rs_q,       rs_d;
    logic [4:0]    rt_q,       rt_d;
    logic [4:0]    rd_q,       rd_d;
    logic          valid_q,    valid_d;
    logic [CW-1:0] bcnt_q,     bcnt_d;

    // ------------------------------------------------------------------------
    // Load-use hazard detection
    // ------------------------------------------------------------------------
    // The decode instruction reads rt as a source unless it takes its second
    // ALU operand from the immediate; stores read rt for the write data even
    // though they use the immediate for the address.
    logic w_uses_rt;
    logic w_ex_is_load;
    logic w_rs_match;
    logic w_rt_match;
    logic w_stall;

    assign w_uses_rt    = ~ctlex_in[c_ALUSRC_BIT] | ctlm_in[c_MEMWRITE_BIT];
    // $zero never carries a real dependency, so a load into r0 is ignored.
    assign w_ex_is_load = valid_q & m_q[c_MEMREAD_BIT] & (rt_q != 5'd0);
    assign w_rs_match   = (rt_q == rs_in);
    assign w_rt_match   = w_uses_rt & (rt_q == rt_in);
    assign w_stall      = w_ex_is_load & id_valid & (w_rs_match | w_rt_match);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // The datapath and specifier fields load on every edge except a plain
    // hold: a flush or bubble only needs the control and valid bits cleared,
    // the data under a dead slot is don't-care but loading keeps it simple.
    logic w_load_data;
    assign w_load_data = flush | ~hold;

    always_comb begin
        ex_d     = ex_q;
        m_d      = m_q;
        wb_d     = wb_q;
        valid_d  = valid_q;
        bcnt_d   = bcnt_q;
        npc_d    = npc_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        sext_d   = sext_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;

        if (flush) begin
            // Taken branch kills the slot; wins over hold and stall.
            ex_d    = '0;
            m_d     = '0;
            wb_d    = '0;
            valid_d = 1'b0;
        end else if (hold) begin
            // Downstream stall: everything keeps its value.
        end else if (w_stall) begin
            // Bubble: the dependent instruction is held upstream and loads on
            // the following edge. Clearing MemRead here is what limits the
            // stall to a single cycle.
            ex_d    = '0;
            m_d     = '0;
            wb_d    = '0;
            valid_d = 1'b0;
            if (bcnt_q != c_CNT_MAX) begin
                bcnt_d = bcnt_q + c_CNT_ONE;
            end
        end else begin
            ex_d    = id_valid ? ctlex_in : 4'd0;
            m_d     = id_valid ? ctlm_in  : 3'd0;
            wb_d    = id_valid ? ctlwb_in : 2'd0;
            valid_d = id_valid;
        end

        if (w_load_data) begin
            npc_d    = npc_in;
            rdata1_d = rdata1_in;
            rdata2_d = rdata2_in;
            sext_d   = sext_in;
            rs_d     = rs_in;
            rt_d     = rt_in;
            rd_d     = rd_in;
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= '0;
            m_q      <= '0;
            wb_q     <= '0;
            valid_q  <= 1'b0;
            bcnt_q   <= '0;
            npc_q    <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            sext_q   <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
        end else begin
            ex_q     <= ex_d;
            m_q      <= m_d;
            wb_q     <= wb_d;
            valid_q  <= valid_d;
            bcnt_q   <= bcnt_d;
            npc_q    <= npc_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            sext_q   <= sext_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ex_out     = ex_q;
    assign m_out      = m_q;
    assign wb_out     = wb_q;
    assign npc_out    = npc_q;
    assign rdata1_out = rdata1_q;
    assign rdata2_out = rdata2_q;
    assign sext_out   = sext_q;
    assign rs_out     = rs_q;
    assign rt_out     = rt_q;
    assign rd_out     = rd_q;
    assign ex_valid   = valid_q;
    assign stall_out  = w_stall;
    assign bubble_cnt = bcnt_q;

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute in the five-stage MIPS pipeline. It latches the decode control bundle (EX/M/WB), register-file read data, sign-extended immediate, next PC and register specifiers. It detects load-use hazards against the instruction currently in EX. On a hazard it drives a one-cycle stall upstream and inserts a bubble downstream. It also honours branch flush and a global pipeline hold, and keeps a saturating bubble counter for debug.

## Interface
- `DW`, 32, datapath width (PC, read data, immediate)
- `CW`, 16, bubble counter width
- `clk` in 1, rising-edge clock
- `rst_n` in 1, asynchronous active-low reset
- `ctlex_in` in 4, {RegDst, ALUOp[1:0], ALUSrc} from control
- `ctlm_in` in 3, {Branch, MemRead, MemWrite}
- `ctlwb_in` in 2, {RegWrite, MemtoReg}
- `id_valid` in 1, decode slot holds a real instruction
- `npc_in`, `rdata1_in`, `rdata2_in`, `sext_in` in DW each, next PC, rs data, rt data, sign-extended imm
- `rs_in`, `rt_in`, `rd_in` in 5 each, instr[25:21], [20:16], [15:11]
- `flush` in 1, kill decode slot (branch taken in MEM)
- `hold` in 1, freeze this register (downstream stall)
- `ex_out` out 4, `m_out` out 3, `wb_out` out 2, registered control
- `npc_out`, `rdata1_out`, `rdata2_out`, `sext_out` out DW, registered datapath
- `rs_out`, `rt_out`, `rd_out` out 5, registered specifiers
- `ex_valid` out 1, EX slot holds a real instruction
- `stall_out` out 1, combinational; hold PC and IF/ID this cycle
- `bubble_cnt` out CW, saturating count of inserted bubbles

## Operation
- Reset is asynchronous, active-low, one clock, as fixed for this block. While `rst_n`=0, every registered output is 0: control, datapath, specifiers, `ex_valid`, `bubble_cnt`. Consequently `stall_out`=0.
- Hazard (comb): `uses_rt` = !ctlex_in[0] | ctlm_in[0].
- `stall_out` = ex_valid & m_out[1] & (rt_out≠0) & id_valid & ((rt_out==rs_in) | (uses_rt & rt_out==rt_in)).
- Per-edge priority, highest first:
  1. flush: control outputs ← 0, `ex_valid` ← 0; datapath/specifiers load inputs; no count.
  2. hold: all registers keep value; `bubble_cnt` unchanged.
  3. stall_out: bubble; control ← 0, `ex_valid` ← 0; datapath/specifiers load inputs; `bubble_cnt` +1, saturating at 2^CW−1.
  4. else load. Control ← inputs gated by `id_valid`: zero when `id_valid`=0. `ex_valid` ← id_valid. All datapath fields load.
- A bubble clears `m_out[1]`, so a stall lasts exactly one cycle per load-use pair.
- Register 0 never causes a stall.
- `stall_out` stays asserted while `hold` is high; upstream must also honour `hold`.

## Timing
- Latency one cycle: inputs sampled at edge N appear on outputs after edge N.
- `stall_out` is valid the same cycle as the offending decode inputs. The bubble appears after that edge, and the dependent instruction loads at the next edge, because the upstream stage held it.
- flush + stall in the same cycle: flush wins; no count.
- flush + hold in the same cycle: flush wins; the slot is killed.
- Reset asserted mid-stall: outputs clear immediately; `stall_out` drops combinationally.

## Test plan
- Reset: drive `rst_n`=0 with all inputs nonzero. Then: every output is 0. After release, `ctlex_in`=4'b1100, `ctlwb_in`=2'b10, `id_valid`=1. Then: `ex_out`=1100 and `wb_out`=10 after one edge.
- Load-use on rs: EX holds LW (`m_out`=010, `rt_out`=8), decode rs_in=8. Then: `stall_out`=1, the next edge gives `ex_out`/`m_out`/`wb_out`=0, `ex_valid`=0, `bubble_cnt`=1, and the following edge loads the instruction.
- rt source and destination: EX LW with rt_out=9. R-type decode with rt_in=9: stall. LW decode with rt_in=9 and rs_in=3: no stall. SW decode with rt_in=9: stall. LW with rt_out=0 and rs_in=0: no stall.
- Flush priority: stall condition plus `flush`=1. Then: bubble inserted, `bubble_cnt` unchanged, `ex_valid`=0.
- Hold: `hold`=1 for 3 cycles with changing inputs. Then: outputs frozen. Release with no hazard: the new inputs load.
- Saturation: CW=2, force 5 bubbles. Then: `bubble_cnt` reads 1, 2, 3, 3, 3.
